fft_deserializer: RTL and testbench

FFT_DESERIALIZER -- requirements
Module: fft_deserializer

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_deserializer.sv | 104 ++++++++++
 tb/tb_fft_deserializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT-datapath types and index helpers, used by the deserializer, twiddle and crossbar blocks.
package fft_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_t;

  // Reverse the low log2n bits of index; higher result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] index, input int log2n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < log2n) r[i] = index[5'(log2n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_deserializer.sv
// Collects N_SAMPLES serial complex samples into one parallel frame; send_val rises 1 cycle after the last accept.
// While a frame waits, recv_rdy follows send_rdy so a new sample can land in slot idx(0) on the handoff edge.
module fft_deserializer
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int DECIMAL_PT  = 16,
  parameter int N_SAMPLES   = 8,
  parameter int BIT_REVERSE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg_real,
  input  logic [BIT_WIDTH-1:0] recv_msg_imag,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg_real [N_SAMPLES-1:0],
  output logic [BIT_WIDTH-1:0] send_msg_imag [N_SAMPLES-1:0],
  output logic                 send_val,
  input  logic                 send_rdy
);

  localparam int CW = $clog2(N_SAMPLES);

  if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0 ||
      DECIMAL_PT < 0 || DECIMAL_PT > BIT_WIDTH) begin : g_param_check
    $error("fft_deserializer: illegal N_SAMPLES or DECIMAL_PT");
  end

  fill_state_t   state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [CW-1:0] wr_sel, wr_idx;
  logic          wr_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    wr_en      = 1'b0;
    wr_sel     = cnt;
    recv_rdy   = 1'b1;
    send_val   = 1'b0;
    case (state)
      FILL: begin
        if (recv_val) begin
          wr_en = 1'b1;
          if (cnt == CW'(N_SAMPLES - 1)) begin
            next_state = FULL;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end
      FULL: begin
        send_val = 1'b1;
        recv_rdy = send_rdy;
        if (send_rdy) begin
          next_state = FILL;
          // A sample arriving on the handoff edge starts the next frame.
          if (recv_val) begin
            wr_en    = 1'b1;
            wr_sel   = '0;
            next_cnt = CW'(1);
          end else begin
            next_cnt = '0;
          end
        end
      end
      default: begin
        next_state = FILL;
        next_cnt   = '0;
      end
    endcase
  end

  if (BIT_REVERSE != 0) begin : g_rev
    assign wr_idx = CW'(bitrev(32'(wr_sel), CW));
  end else begin : g_lin
    assign wr_idx = wr_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        send_msg_real[k] <= '0;
        send_msg_imag[k] <= '0;
      end
    end else if (wr_en) begin
      send_msg_real[wr_idx] <= recv_msg_real;
      send_msg_imag[wr_idx] <= recv_msg_imag;
    end
  end

endmodule

// File: tb/tb_fft_deserializer.sv
// Directed bench for fft_deserializer: linear and bit-reversed instances share one stimulus stream.
module tb_fft_deserializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_re = '0;
  logic [31:0] in_im = '0;
  logic        recv_val = 1'b0;
  logic        send_rdy = 1'b0;

  logic        r_rdy, s_val, b_rdy, b_val;
  logic [31:0] s_re [7:0];
  logic [31:0] s_im [7:0];
  logic [31:0] b_re [7:0];
  logic [31:0] b_im [7:0];

  int vecs = 0;
  int miscompares = 0;
  int br_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft_deserializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .BIT_REVERSE(0)) dut (
    .clk(clk), .reset(reset),
    .recv_msg_real(in_re), .recv_msg_imag(in_im), .recv_val(recv_val), .recv_rdy(r_rdy),
    .send_msg_real(s_re), .send_msg_imag(s_im), .send_val(s_val), .send_rdy(send_rdy)
  );

  fft_deserializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .BIT_REVERSE(1)) dut_br (
    .clk(clk), .reset(reset),
    .recv_msg_real(in_re), .recv_msg_imag(in_im), .recv_val(recv_val), .recv_rdy(b_rdy),
    .send_msg_real(b_re), .send_msg_imag(b_im), .send_val(b_val), .send_rdy(send_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one sample for exactly one rising edge (called just after an edge).
  task automatic feed(input logic [31:0] re, input logic [31:0] im);
    recv_val = 1'b1;
    in_re    = re;
    in_im    = im;
    @(posedge clk);
    #1;
    recv_val = 1'b0;
  endtask

  initial begin
    int k, guard, early, frames, rdy_low, spacing_bad, f;

    #1 reset = 1'b0;
    #11;
    chk("rst_val", 32'(s_val), 0);
    for (int i = 0; i < 8; i++) begin
      chk("rst_re", s_re[i], 0);
      chk("rst_im", s_im[i], 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rdy", 32'(r_rdy), 1);

    // Back-to-back frame, send_rdy high.
    send_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_early", 32'(s_val), 0);
      feed(32'(i + 1), 32'(-(i + 1)));
    end
    chk("b2b_lat1", 32'(s_val), 1);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_re", s_re[i], 32'(i + 1));
      chk("b2b_im", s_im[i], 32'(-(i + 1)));
    end
    @(posedge clk);
    #1;
    chk("b2b_drain", 32'(s_val), 0);

    // Bit-reversed placement.
    for (int i = 0; i < 8; i++) feed(32'(i), 32'(i + 50));
    chk("br_val", 32'(b_val), 1);
    for (int i = 0; i < 8; i++) begin
      chk("br_re", b_re[i], 32'(br_exp[i]));
      chk("br_im", b_im[i], 32'(br_exp[i] + 50));
      chk("lin_re", s_re[i], 32'(i));
    end
    @(posedge clk);
    #1;

    // Backpressure with a pending sample.
    send_rdy = 1'b0;
    for (int i = 0; i < 8; i++) feed(32'(40 + i), 0);
    chk("bp_full", 32'(s_val), 1);
    recv_val = 1'b1;
    in_re = 48;
    in_im = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rdy", 32'(r_rdy), 0);
      chk("bp_rdy_br", 32'(b_rdy), 0);
      chk("bp_val", 32'(s_val), 1);
      chk("bp_s0", s_re[0], 40);
      chk("bp_s7", s_re[7], 47);
      @(posedge clk);
      #1;
    end
    send_rdy = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(r_rdy), 1);
    chk("bp_out_s0", s_re[0], 40);
    @(posedge clk);
    #1;
    recv_val = 1'b0;
    chk("bp_hand_val", 32'(s_val), 0);
    chk("bp_s0_new", s_re[0], 48);
    chk("bp_s1_kept", s_re[1], 41);
    for (int i = 1; i < 8; i++) feed(32'(48 + i), 0);
    chk("bp_next_val", 32'(s_val), 1);
    for (int i = 0; i < 8; i++) chk("bp_next_re", s_re[i], 32'(48 + i));
    @(posedge clk);
    #1;

    // Random gaps on recv_val.
    k = 0; guard = 0; early = 0;
    while (k < 8 && guard < 100) begin
      if ($urandom_range(0, 1) == 1) begin
        recv_val = 1'b1;
        in_re = 32'(100 + k);
        in_im = 32'(k);
      end else begin
        recv_val = 1'b0;
      end
      #1;
      if (s_val) early++;
      @(posedge clk);
      #1;
      if (recv_val) k++;
      guard++;
    end
    recv_val = 1'b0;
    chk("gap_count", 32'(k), 8);
    chk("gap_early", 32'(early), 0);
    chk("gap_val", 32'(s_val), 1);
    for (int i = 0; i < 8; i++) chk("gap_re", s_re[i], 32'(100 + i));
    @(posedge clk);
    #1;

    // Continuous streaming: one frame every 8 cycles.
    recv_val = 1'b1;
    send_rdy = 1'b1;
    frames = 0; rdy_low = 0; spacing_bad = 0;
    for (int c = 0; c < 72; c++) begin
      in_re = 32'(200 + c);
      in_im = 32'(c);
      #1;
      if (!r_rdy) rdy_low++;
      if (s_val != (c >= 8 && c % 8 == 0)) spacing_bad++;
      if (s_val) begin
        f = frames;
        chk("stream_s0", s_re[0], 32'(200 + 8 * f));
        chk("stream_s7", s_re[7], 32'(207 + 8 * f));
        frames++;
      end
      @(posedge clk);
      #1;
    end
    recv_val = 1'b0;
    chk("stream_frames", 32'(frames), 8);
    chk("stream_rdy_low", 32'(rdy_low), 0);
    chk("stream_spacing", 32'(spacing_bad), 0);
    @(posedge clk);
    #1;
    chk("stream_drain", 32'(s_val), 0);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) feed(32'(9 + i), 0);
    reset = 1'b0;
    #2;
    chk("mid_rst_val", 32'(s_val), 0);
    for (int i = 0; i < 8; i++) chk("mid_rst_re", s_re[i], 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("mid_early", 32'(s_val), 0);
      feed(32'(20 + i), 0);
    end
    chk("mid_val", 32'(s_val), 1);
    for (int i = 0; i < 8; i++) chk("mid_re", s_re[i], 32'(20 + i));
    @(posedge clk);
    #1;

    // Reset while a frame is pending.
    send_rdy = 1'b0;
    for (int i = 0; i < 8; i++) feed(32'(30 + i), 0);
    chk("full_pend", 32'(s_val), 1);
    reset = 1'b0;
    #2;
    chk("full_rst_val", 32'(s_val), 0);
    chk("full_rst_s3", s_re[3], 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("full_after_val", 32'(s_val), 0);
    chk("full_after_rdy", 32'(r_rdy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
